// File: rtl/fp_seq_unit.sv
// Multi-cycle FP32 add/sub/mul unit behind the execute-stage FPU stall handshake.
// IDLE -> UNPACK -> OP -> NORM -> ROUND; results register four edges after start.
module fp_seq_unit (
   input  logic        clk,
   input  logic        Rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  fpusel,
   input  logic [2:0]  rm,
   output logic [31:0] res,
   output logic [4:0]  fflags,
   output logic        done,
   output logic        f_stall
);
   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_OP, S_NORM, S_ROUND} state_t;
   localparam logic [4:0]  OP_ADD = 5'd1, OP_SUB = 5'd2, OP_MUL = 5'd3;
   localparam logic [31:0] QNAN   = 32'h7fc0_0000;

   state_t state_q, state_d;

   logic [31:0] a_q, b_q, spec_res_q, spec_res_d, res_q, res_d;
   logic [4:0]  op_q, spec_fl_q, spec_fl_d, fflags_q, fflags_d;
   logic        rtz_q, done_q;
   logic        sa_q, sb_q, mul_q, spec_q, sb_d, mul_d, spec_d;
   logic [7:0]  ea_q, eb_q;
   logic [23:0] ma_q, mb_q, ma_d, mb_d;
   logic        sign_q, zsign_q, sign_d, zsign_d;
   logic signed [9:0] exp_q, exp_d, expn_q, expn_d, exp_f;
   logic [47:0] sig_q, sig_d;
   logic [23:0] mant_q, mant_d;
   logic        g_q, r_q, s_q, zero_q, g_d, r_d, s_d, zero_d;

   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, legal;
   logic a_big, inc, nx;
   logic [7:0]  e_big, e_sml, diff;
   logic [23:0] m_big, m_sml;
   logic [26:0] sml_ext, shifted, aligned;
   logic [27:0] sum;
   logic [47:0] prod, norm;
   logic [5:0]  lz;
   logic [24:0] mant_r;
   logic [22:0] frac;

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      f_stall = 1'b0;
      case (state_q)
         S_IDLE: begin
            f_stall = start & ~Rst;
            if (start) state_d = S_UNPACK;
         end
         S_UNPACK: begin f_stall = ~Rst; state_d = S_OP;    end
         S_OP:     begin f_stall = ~Rst; state_d = S_NORM;  end
         S_NORM:   begin f_stall = ~Rst; state_d = S_ROUND; end
         S_ROUND:  begin f_stall = ~Rst; state_d = S_IDLE;  end
         default:  state_d = S_IDLE;
      endcase
   end

   assign a_zero = (a_q[30:23] == 8'd0);
   assign b_zero = (b_q[30:23] == 8'd0);
   assign a_inf  = (a_q[30:23] == 8'hff) && (a_q[22:0] == 23'd0);
   assign b_inf  = (b_q[30:23] == 8'hff) && (b_q[22:0] == 23'd0);
   assign a_nan  = (a_q[30:23] == 8'hff) && (a_q[22:0] != 23'd0);
   assign b_nan  = (b_q[30:23] == 8'hff) && (b_q[22:0] != 23'd0);
   assign a_snan = a_nan & ~a_q[22];
   assign b_snan = b_nan & ~b_q[22];
   assign legal  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);
   assign mul_d  = (op_q == OP_MUL);
   assign sb_d   = b_q[31] ^ (op_q == OP_SUB);
   assign ma_d   = a_zero ? 24'd0 : {1'b1, a_q[22:0]};
   assign mb_d   = b_zero ? 24'd0 : {1'b1, b_q[22:0]};

   // Specials resolve in UNPACK and ride alongside the datapath to keep latency fixed.
   always_comb begin
      spec_d     = 1'b1;
      spec_res_d = QNAN;
      spec_fl_d  = 5'd0;
      if (!legal)
         spec_res_d = 32'd0;
      else if (a_nan | b_nan)
         spec_fl_d[4] = a_snan | b_snan;
      else if (mul_d ? ((a_zero & b_inf) | (a_inf & b_zero)) : (a_inf & b_inf & (a_q[31] != sb_d)))
         spec_fl_d[4] = 1'b1;
      else if (a_inf | b_inf)
         spec_res_d = {(mul_d ? (a_q[31] ^ sb_d) : (a_inf ? a_q[31] : sb_d)), 8'hff, 23'd0};
      else
         spec_d = 1'b0;
   end

   always_comb begin
      a_big   = {ea_q, ma_q} >= {eb_q, mb_q};
      e_big   = a_big ? ea_q : eb_q;
      e_sml   = a_big ? eb_q : ea_q;
      m_big   = a_big ? ma_q : mb_q;
      m_sml   = a_big ? mb_q : ma_q;
      diff    = e_big - e_sml;
      sml_ext = {m_sml, 3'b000};
      shifted = sml_ext >> diff;
      if (diff >= 8'd26) aligned = {26'd0, |m_sml};
      else               aligned = shifted | {26'd0, ((shifted << diff) != sml_ext)};
      if (sa_q == sb_q) sum = {1'b0, m_big, 3'b000} + {1'b0, aligned};
      else              sum = {1'b0, m_big, 3'b000} - {1'b0, aligned};
      prod = {24'd0, ma_q} * {24'd0, mb_q};
      if (mul_q) begin
         sig_d   = prod;
         exp_d   = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
         sign_d  = sa_q ^ sb_q;
         zsign_d = sa_q ^ sb_q;
      end else begin
         sig_d   = {sum, 20'd0};
         exp_d   = $signed({2'b00, e_big});
         sign_d  = a_big ? sa_q : sb_q;
         zsign_d = sa_q & sb_q;
      end
   end

   // Leading one is moved to bit 47; exponent was set for a leading one at bit 46.
   always_comb begin
      lz = 6'd0;
      for (int i = 0; i < 48; i++)
         if (sig_q[i]) lz = 6'(47 - i);
      norm   = sig_q << lz;
      mant_d = norm[47:24];
      g_d    = norm[23];
      r_d    = norm[22];
      s_d    = |norm[21:0];
      expn_d = exp_q + 10'sd1 - $signed({4'd0, lz});
      zero_d = (sig_q == 48'd0);
   end

   always_comb begin
      inc      = ~rtz_q & g_q & (r_q | s_q | mant_q[0]);
      nx       = g_q | r_q | s_q;
      mant_r   = {1'b0, mant_q} + {24'd0, inc};
      frac     = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
      exp_f    = expn_q + $signed({9'd0, mant_r[24]});
      res_d    = {sign_q, exp_f[7:0], frac};
      fflags_d = {4'd0, nx};
      if (spec_q) begin
         res_d    = spec_res_q;
         fflags_d = spec_fl_q;
      end else if (zero_q) begin
         res_d    = {zsign_q, 31'd0};
         fflags_d = 5'd0;
      end else if (exp_f >= 10'sd255) begin
         res_d    = {sign_q, (rtz_q ? 31'h7f7f_ffff : 31'h7f80_0000)};
         fflags_d = 5'b00101;
      end else if (exp_f <= 10'sd0) begin
         res_d    = {sign_q, 31'd0};
         fflags_d = 5'b00011;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all stages update together.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         a_q <= '0; b_q <= '0; op_q <= '0; rtz_q <= 1'b0;
         sa_q <= 1'b0; sb_q <= 1'b0; mul_q <= 1'b0; spec_q <= 1'b0;
         ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
         spec_res_q <= '0; spec_fl_q <= '0;
         sign_q <= 1'b0; zsign_q <= 1'b0; exp_q <= '0; sig_q <= '0;
         mant_q <= '0; g_q <= 1'b0; r_q <= 1'b0; s_q <= 1'b0; zero_q <= 1'b0; expn_q <= '0;
         res_q <= '0; fflags_q <= '0; done_q <= 1'b0;
      end else begin
         done_q <= (state_q == S_ROUND);
         case (state_q)
            S_IDLE: if (start) begin
               a_q <= a; b_q <= b; op_q <= fpusel; rtz_q <= (rm == 3'd1);
            end
            S_UNPACK: begin
               sa_q <= a_q[31]; sb_q <= sb_d; mul_q <= mul_d;
               ea_q <= a_q[30:23]; eb_q <= b_q[30:23]; ma_q <= ma_d; mb_q <= mb_d;
               spec_q <= spec_d; spec_res_q <= spec_res_d; spec_fl_q <= spec_fl_d;
            end
            S_OP: begin
               sign_q <= sign_d; zsign_q <= zsign_d; exp_q <= exp_d; sig_q <= sig_d;
            end
            S_NORM: begin
               mant_q <= mant_d; g_q <= g_d; r_q <= r_d; s_q <= s_d;
               zero_q <= zero_d; expn_q <= expn_d;
            end
            S_ROUND: begin
               res_q <= res_d; fflags_q <= fflags_d;
            end
            default: ;
         endcase
      end
   end

   assign res    = res_q;
   assign fflags = fflags_q;
   assign done   = done_q;
endmodule

// File: tb/tb_fp_seq_unit.sv
// Directed bench for fp_seq_unit: vector table plus back-to-back and mid-op reset sequences.
module tb_fp_seq_unit;
   logic        clk, Rst, start;
   logic [31:0] a, b, res;
   logic [4:0]  fpusel, fflags;
   logic [2:0]  rm;
   logic        done, f_stall;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [4:0]  sel;
      logic [2:0]  mode;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp_res;
      logic [4:0]  exp_fl;
   } vec_t;

   vec_t vecs[15];

   fp_seq_unit dut (
      .clk(clk), .Rst(Rst), .start(start), .a(a), .b(b), .fpusel(fpusel), .rm(rm),
      .res(res), .fflags(fflags), .done(done), .f_stall(f_stall)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives a start in the current cycle, returns done latency (edges after acceptance) and stall-cycle count.
   task automatic run_op(input logic [4:0] sel, input logic [2:0] mode, input logic [31:0] x,
                         input logic [31:0] y, output int lat, output int stalls);
      stalls = 0;
      lat    = -1;
      fpusel = sel; rm = mode; a = x; b = y; start = 1'b1;
      #1;
      if (f_stall) stalls++;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         start = 1'b0; a = $urandom; b = $urandom; fpusel = 5'($urandom); rm = 3'($urandom);
         #1;
         if (f_stall) stalls++;
         if (done) begin
            lat = j;
            break;
         end
      end
   endtask

   task automatic check_op(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_fl,
                           input int lat, input int stalls);
      check($sformatf("%s latency", tag), 32'(lat), 32'd4);
      check($sformatf("%s stall_cycles", tag), 32'(stalls), 32'd5);
      check($sformatf("%s res", tag), res, exp_res);
      check($sformatf("%s fflags", tag), 32'(fflags), 32'(exp_fl));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, stalls, dn;
      vecs[0]  = '{5'd1, 3'd0, 32'h408ccccd, 32'h400ccccd, 32'h40d33334, 5'h01};
      vecs[1]  = '{5'd1, 3'd1, 32'h408ccccd, 32'h400ccccd, 32'h40d33333, 5'h01};
      vecs[2]  = '{5'd2, 3'd0, 32'h3f800000, 32'h3f000000, 32'h3f000000, 5'h00};
      vecs[3]  = '{5'd1, 3'd0, 32'h7f800000, 32'hff800000, 32'h7fc00000, 5'h10};
      vecs[4]  = '{5'd3, 3'd0, 32'h00000000, 32'h7f800000, 32'h7fc00000, 5'h10};
      vecs[5]  = '{5'd1, 3'd0, 32'h7fa00000, 32'h3f800000, 32'h7fc00000, 5'h10};
      vecs[6]  = '{5'd1, 3'd0, 32'h7fc00001, 32'h3f800000, 32'h7fc00000, 5'h00};
      vecs[7]  = '{5'd3, 3'd0, 32'h7f000000, 32'h40000000, 32'h7f800000, 5'h05};
      vecs[8]  = '{5'd3, 3'd1, 32'h7f000000, 32'h40000000, 32'h7f7fffff, 5'h05};
      vecs[9]  = '{5'd3, 3'd0, 32'h00800000, 32'h3f000000, 32'h00000000, 5'h03};
      vecs[10] = '{5'd1, 3'd0, 32'h80000000, 32'h80000000, 32'h80000000, 5'h00};
      vecs[11] = '{5'd3, 3'd0, 32'hc0000000, 32'h40400000, 32'hc0c00000, 5'h00};
      vecs[12] = '{5'd2, 3'd0, 32'h3f800000, 32'h7f800000, 32'hff800000, 5'h00};
      vecs[13] = '{5'd7, 3'd0, 32'h3f800000, 32'h3f800000, 32'h00000000, 5'h00};
      vecs[14] = '{5'd1, 3'd0, 32'h7f800000, 32'h3f800000, 32'h7f800000, 5'h00};

      Rst = 1'b1; start = 1'b0; a = '0; b = '0; fpusel = '0; rm = '0;
      for (int t = 0; t < 2; t++) begin
         #6;
         check("reset res", res, 32'd0);
         check("reset fflags", 32'(fflags), 32'd0);
         check("reset done", 32'(done), 32'd0);
         check("reset f_stall", 32'(f_stall), 32'd0);
      end
      #3 Rst = 1'b0;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk); #1;
         check("idle outputs", {res[26:0], fflags}, 32'd0);
         check("idle done/stall", {30'd0, done, f_stall}, 32'd0);
      end

      foreach (vecs[i]) begin
         @(negedge clk);
         run_op(vecs[i].sel, vecs[i].mode, vecs[i].x, vecs[i].y, lat, stalls);
         check_op($sformatf("v%0d", i), vecs[i].exp_res, vecs[i].exp_fl, lat, stalls);
      end

      // Back-to-back: fmul issued in the done cycle of the fsub.
      @(negedge clk);
      run_op(5'd2, 3'd0, 32'h3f800000, 32'h3f800000, lat, stalls);
      check_op("b2b fsub", 32'h00000000, 5'h00, lat, stalls);
      run_op(5'd3, 3'd0, 32'h40000000, 32'h40400000, lat, stalls);
      check_op("b2b fmul", 32'h40c00000, 5'h00, lat, stalls);

      // Reset while the op sits in OP state.
      @(negedge clk);
      fpusel = 5'd1; rm = 3'd0; a = 32'h3f800000; b = 32'h3f800000; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      check("pre-reset f_stall", 32'(f_stall), 32'd1);
      Rst = 1'b1;
      #1;
      check("midop f_stall", 32'(f_stall), 32'd0);
      check("midop res", res, 32'd0);
      check("midop fflags", 32'(fflags), 32'd0);
      @(negedge clk); Rst = 1'b0;
      dn = 0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk); #1;
         if (done || f_stall) dn++;
      end
      check("midop no done", 32'(dn), 32'd0);
      check("midop res held", res, 32'd0);
      @(negedge clk);
      run_op(5'd1, 3'd0, 32'h3f800000, 32'h3f800000, lat, stalls);
      check_op("post-reset fadd", 32'h40000000, 5'h00, lat, stalls);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
